// File: rtl/risc32_issue_ctrl.sv
// Issue/hazard controller between decode and execute: per-register countdown
// scoreboard for RAW stalls, branch hold, and HALT drain for a forwarding-free pipeline.
module risc32_issue_ctrl #(
  parameter int ALU_LAT  = 2,
  parameter int LOAD_LAT = 3,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [4:0]  id_rd,
  input  logic        id_wr_en,
  input  logic        id_is_load,
  input  logic        id_is_branch,
  input  logic        id_is_halt,
  input  logic        br_resolve,
  input  logic        ext_hold,
  input  logic        restart,
  output logic        issue,
  output logic        stall,
  output logic        halted,
  output logic [31:0] busy_mask,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_DRAIN   = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t      state_q;
  logic        halted_q;
  logic [15:0] stall_cnt_q;
  logic [31:0] busy;
  logic        hazard;

  // busy[0] is constant 0, so an R0 source can never raise a hazard.
  assign hazard = (id_rs_used && (id_rs != 5'd0) && busy[id_rs]) ||
                  (id_rt_used && (id_rt != 5'd0) && busy[id_rt]);

  // Gated with rst_n so issue/stall drop immediately while reset is held.
  assign issue = rst_n && id_valid && (state_q == S_RUN) && !hazard && !ext_hold;
  assign stall = rst_n && id_valid && !issue;

  for (genvar gi = 0; gi < 32; gi++) begin : g_sb
    if (gi == 0) begin : g_r0
      assign busy[gi] = 1'b0;
    end else begin : g_rk
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // A new producer reloads the counter, overriding the decrement (WAW included).
      always_comb begin
        cnt_d = (cnt_q != '0) ? cnt_q - ONE_CNT : '0;
        if (issue && id_wr_en && (id_rd == 5'(gi))) begin
          cnt_d = id_is_load ? LOAD_CNT : ALU_CNT;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign busy[gi] = (cnt_q != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      case (state_q)
        S_RUN: begin
          if (issue && id_is_halt) begin
            state_q <= S_DRAIN;
          end else if (issue && id_is_branch) begin
            state_q <= S_BR_WAIT;
          end
        end
        S_BR_WAIT: begin
          if (br_resolve) begin
            state_q <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (busy == 32'd0) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: begin
          // Restart clear wins over the increment from a stall in this same cycle.
          if (restart) begin
            state_q     <= S_RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign halted    = halted_q;
  assign busy_mask = busy;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_risc32_issue_ctrl.sv
// Scoreboard bench for risc32_issue_ctrl: per-cycle expected outputs are queued at
// drive time and compared against the DUT shortly after the falling edge.
module tb_risc32_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load;
  logic        id_is_branch, id_is_halt, br_resolve, ext_hold, restart;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        issue, stall, halted;
  logic [31:0] busy_mask;
  logic [15:0] stall_cnt;

  risc32_issue_ctrl #(.ALU_LAT(2), .LOAD_LAT(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_is_halt(id_is_halt),
    .br_resolve(br_resolve), .ext_hold(ext_hold), .restart(restart), .issue(issue),
    .stall(stall), .halted(halted), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic [4:0] rd;
    logic       wr, ld, br, hlt, brr, xh, rsrt;
  } stim_t;

  typedef struct packed {
    logic        issue, stall, halted;
    logic [31:0] busy;
    logic [15:0] scnt;
  } exp_t;

  typedef struct packed {
    stim_t       s;
    logic        issue, stall, halted;
    logic [31:0] busy;
  } row_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_sc = 16'd0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t ins(input logic [4:0] rd, input logic wr, input logic [4:0] rs,
                                input logic rsu, input logic [4:0] rt, input logic rtu,
                                input logic ld);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rd = rd; s.wr = wr; s.rs = rs; s.rsu = rsu;
    s.rt = rt; s.rtu = rtu; s.ld = ld;
    return s;
  endfunction

  function automatic stim_t ctl(input stim_t si, input logic br, input logic hlt,
                                input logic brr, input logic xh, input logic rsrt);
    stim_t s;
    s = si;
    s.br = br; s.hlt = hlt; s.brr = brr; s.xh = xh; s.rsrt = rsrt;
    return s;
  endfunction

  function automatic row_t row(input stim_t s, input logic i, input logic st,
                               input logic h, input logic [31:0] b);
    row_t r;
    r.s = s; r.issue = i; r.stall = st; r.halted = h; r.busy = b;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic i, input logic st, input logic h,
                                  input logic [31:0] b, input logic [15:0] sc);
    exp_t e;
    e.issue = i; e.stall = st; e.halted = h; e.busy = b; e.scnt = sc;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.v; id_rs = s.rs; id_rs_used = s.rsu; id_rt = s.rt; id_rt_used = s.rtu;
    id_rd = s.rd; id_wr_en = s.wr; id_is_load = s.ld; id_is_branch = s.br;
    id_is_halt = s.hlt; br_resolve = s.brr; ext_hold = s.xh; restart = s.rsrt;
  endtask

  task automatic test_reset();
    exp_t e, obs;
    // Reset held with a valid, hazard-free instruction: nothing may issue.
    drive(ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0));
    sb.push_back(mk_exp(1'b0, 1'b0, 1'b0, 32'd0, 16'd0));
    #1;
    e = sb.pop_front();
    obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
    checks++;
    $display("[reset held] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
             issue, stall, halted, busy_mask, stall_cnt);
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle());
    sb.push_back(mk_exp(1'b0, 1'b0, 1'b0, 32'd0, 16'd0));
    #1;
    e = sb.pop_front();
    obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
    checks++;
    $display("[reset released] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
             issue, stall, halted, busy_mask, stall_cnt);
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_released: got %h expected %h", obs, e);
    end
    exp_sc = 16'd0;
    @(negedge clk);
  endtask

  task automatic test_alu_raw();
    row_t plan[$];
    exp_t e, obs;
    plan.push_back(row(ins(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0), 1, 0, 0, 32'h0));
    repeat (2) plan.push_back(row(ins(5'd4, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0), 0, 1, 0, 32'h2));
    plan.push_back(row(ins(5'd4, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0), 1, 0, 0, 32'h0));
    repeat (2) plan.push_back(row(idle(), 0, 0, 0, 32'h10));
    plan.push_back(row(idle(), 0, 0, 0, 32'h0));
    for (int c = 0; c < plan.size(); c++) begin
      drive(plan[c].s);
      sb.push_back(mk_exp(plan[c].issue, plan[c].stall, plan[c].halted, plan[c].busy, exp_sc));
      #1;
      e = sb.pop_front();
      obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
      checks++;
      $display("[alu_raw c%0d] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
               c, issue, stall, halted, busy_mask, stall_cnt);
      if (obs !== e) begin
        errors++;
        $display("FAIL alu_raw c%0d: got %h expected %h", c, obs, e);
      end
      if (plan[c].s.rsrt && e.halted) exp_sc = 16'd0;
      else if (e.stall) exp_sc = exp_sc + 16'd1;
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    row_t plan[$];
    exp_t e, obs;
    plan.push_back(row(ins(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1), 1, 0, 0, 32'h0));
    repeat (3) plan.push_back(row(ins(5'd3, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0), 0, 1, 0, 32'h20));
    plan.push_back(row(ins(5'd3, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0), 1, 0, 0, 32'h0));
    repeat (2) plan.push_back(row(idle(), 0, 0, 0, 32'h8));
    plan.push_back(row(idle(), 0, 0, 0, 32'h0));
    // External hold blocks an otherwise clean instruction for one cycle.
    plan.push_back(row(ctl(ins(5'd6, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0), 0, 0, 0, 1, 0),
                       0, 1, 0, 32'h0));
    plan.push_back(row(ins(5'd6, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0), 1, 0, 0, 32'h0));
    repeat (2) plan.push_back(row(idle(), 0, 0, 0, 32'h40));
    plan.push_back(row(idle(), 0, 0, 0, 32'h0));
    for (int c = 0; c < plan.size(); c++) begin
      drive(plan[c].s);
      sb.push_back(mk_exp(plan[c].issue, plan[c].stall, plan[c].halted, plan[c].busy, exp_sc));
      #1;
      e = sb.pop_front();
      obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
      checks++;
      $display("[load_use c%0d] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
               c, issue, stall, halted, busy_mask, stall_cnt);
      if (obs !== e) begin
        errors++;
        $display("FAIL load_use c%0d: got %h expected %h", c, obs, e);
      end
      if (plan[c].s.rsrt && e.halted) exp_sc = 16'd0;
      else if (e.stall) exp_sc = exp_sc + 16'd1;
      @(negedge clk);
    end
  endtask

  task automatic test_r0_waw();
    row_t plan[$];
    exp_t e, obs;
    plan.push_back(row(ins(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0), 1, 0, 0, 32'h0));
    plan.push_back(row(ins(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0), 1, 0, 0, 32'h0));
    plan.push_back(row(ins(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), 1, 0, 0, 32'h0));
    plan.push_back(row(ins(5'd2, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0), 1, 0, 0, 32'h4));
    plan.push_back(row(ins(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), 1, 0, 0, 32'h4));
    // LW R3 while R3 is still pending from the ADDI: counter must reload to 3.
    plan.push_back(row(ins(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), 1, 0, 0, 32'hC));
    repeat (3) plan.push_back(row(idle(), 0, 0, 0, 32'h8));
    plan.push_back(row(idle(), 0, 0, 0, 32'h0));
    for (int c = 0; c < plan.size(); c++) begin
      drive(plan[c].s);
      sb.push_back(mk_exp(plan[c].issue, plan[c].stall, plan[c].halted, plan[c].busy, exp_sc));
      #1;
      e = sb.pop_front();
      obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
      checks++;
      $display("[r0_waw c%0d] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
               c, issue, stall, halted, busy_mask, stall_cnt);
      if (obs !== e) begin
        errors++;
        $display("FAIL r0_waw c%0d: got %h expected %h", c, obs, e);
      end
      if (plan[c].s.rsrt && e.halted) exp_sc = 16'd0;
      else if (e.stall) exp_sc = exp_sc + 16'd1;
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    row_t plan[$];
    exp_t e, obs;
    stim_t nxt;
    nxt = ins(5'd7, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    plan.push_back(row(ctl(ins(5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0), 1, 0, 0, 0, 0),
                       1, 0, 0, 32'h0));
    repeat (4) plan.push_back(row(nxt, 0, 1, 0, 32'h0));
    plan.push_back(row(ctl(nxt, 0, 0, 1, 0, 0), 0, 1, 0, 32'h0));
    plan.push_back(row(nxt, 1, 0, 0, 32'h0));
    repeat (2) plan.push_back(row(idle(), 0, 0, 0, 32'h80));
    plan.push_back(row(idle(), 0, 0, 0, 32'h0));
    // Stray resolve pulse in RUN must not disturb issue.
    plan.push_back(row(ctl(idle(), 0, 0, 1, 0, 0), 0, 0, 0, 32'h0));
    plan.push_back(row(ins(5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0), 1, 0, 0, 32'h0));
    plan.push_back(row(ins(5'd0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0), 1, 0, 0, 32'h0));
    for (int c = 0; c < plan.size(); c++) begin
      drive(plan[c].s);
      sb.push_back(mk_exp(plan[c].issue, plan[c].stall, plan[c].halted, plan[c].busy, exp_sc));
      #1;
      e = sb.pop_front();
      obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
      checks++;
      $display("[branch c%0d] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
               c, issue, stall, halted, busy_mask, stall_cnt);
      if (obs !== e) begin
        errors++;
        $display("FAIL branch c%0d: got %h expected %h", c, obs, e);
      end
      if (plan[c].s.rsrt && e.halted) exp_sc = 16'd0;
      else if (e.stall) exp_sc = exp_sc + 16'd1;
      @(negedge clk);
    end
  endtask

  task automatic test_halt_drain();
    row_t plan[$];
    exp_t e, obs;
    stim_t rd1;
    rd1 = ins(5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    plan.push_back(row(ins(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), 1, 0, 0, 32'h0));
    // HALT with the branch flag also set: HALT must win.
    plan.push_back(row(ctl(ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), 1, 1, 0, 0, 0),
                       1, 0, 0, 32'h40));
    repeat (2) plan.push_back(row(rd1, 0, 1, 0, 32'h40));
    plan.push_back(row(rd1, 0, 1, 0, 32'h0));
    plan.push_back(row(rd1, 0, 1, 1, 32'h0));
    plan.push_back(row(ctl(rd1, 0, 0, 1, 0, 0), 0, 1, 1, 32'h0));
    plan.push_back(row(ctl(rd1, 0, 0, 0, 0, 1), 0, 1, 1, 32'h0));
    plan.push_back(row(rd1, 1, 0, 0, 32'h0));
    // Restart outside HALTED is ignored.
    plan.push_back(row(ctl(idle(), 0, 0, 0, 0, 1), 0, 0, 0, 32'h0));
    plan.push_back(row(rd1, 1, 0, 0, 32'h0));
    for (int c = 0; c < plan.size(); c++) begin
      drive(plan[c].s);
      sb.push_back(mk_exp(plan[c].issue, plan[c].stall, plan[c].halted, plan[c].busy, exp_sc));
      #1;
      e = sb.pop_front();
      obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
      checks++;
      $display("[halt_drain c%0d] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
               c, issue, stall, halted, busy_mask, stall_cnt);
      if (obs !== e) begin
        errors++;
        $display("FAIL halt_drain c%0d: got %h expected %h", c, obs, e);
      end
      if (plan[c].s.rsrt && e.halted) exp_sc = 16'd0;
      else if (e.stall) exp_sc = exp_sc + 16'd1;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    row_t plan[$];
    exp_t e, obs;
    stim_t rd5;
    rd5 = ins(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    plan.push_back(row(ins(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), 1, 0, 0, 32'h0));
    plan.push_back(row(ins(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), 1, 0, 0, 32'h20));
    plan.push_back(row(ctl(ins(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), 1, 0, 0, 0, 0),
                       1, 0, 0, 32'h60));
    plan.push_back(row(rd5, 0, 1, 0, 32'h60));
    for (int c = 0; c < plan.size(); c++) begin
      drive(plan[c].s);
      sb.push_back(mk_exp(plan[c].issue, plan[c].stall, plan[c].halted, plan[c].busy, exp_sc));
      #1;
      e = sb.pop_front();
      obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
      checks++;
      $display("[async_reset c%0d] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
               c, issue, stall, halted, busy_mask, stall_cnt);
      if (obs !== e) begin
        errors++;
        $display("FAIL async_reset c%0d: got %h expected %h", c, obs, e);
      end
      if (e.stall) exp_sc = exp_sc + 16'd1;
      if (c < plan.size() - 1) @(negedge clk);
    end
    // Mid-cycle in BR_WAIT with R5/R6 pending: drop reset between edges.
    #1;
    rst_n = 1'b0;
    exp_sc = 16'd0;
    sb.push_back(mk_exp(1'b0, 1'b0, 1'b0, 32'h0, 16'd0));
    #1;
    e = sb.pop_front();
    obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
    checks++;
    $display("[async_reset asserted] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
             issue, stall, halted, busy_mask, stall_cnt);
    if (obs !== e) begin
      errors++;
      $display("FAIL async_reset_asserted: got %h expected %h", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(rd5);
    sb.push_back(mk_exp(1'b1, 1'b0, 1'b0, 32'h0, 16'd0));
    #1;
    e = sb.pop_front();
    obs = mk_exp(issue, stall, halted, busy_mask, stall_cnt);
    checks++;
    $display("[async_reset released] issue=%0b stall=%0b halted=%0b busy=%08h stall_cnt=%0d",
             issue, stall, halted, busy_mask, stall_cnt);
    if (obs !== e) begin
      errors++;
      $display("FAIL async_reset_released: got %h expected %h", obs, e);
    end
    @(negedge clk);
    drive(idle());
  endtask

  initial begin
    rst_n = 1'b0;
    drive(idle());
    repeat (2) @(negedge clk);
    test_reset();
    test_alu_raw();
    test_load_use();
    test_r0_waw();
    test_branch();
    test_halt_drain();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
